// File: rtl/regs_pkg.sv
// Shared register-file definitions.
// Holds address/data widths, the hard-wired zero register index, the
// register address type and the reset value of the global pointer (GP),
// which the register file itself also uses.
package regs_pkg;
  localparam int REG_AW = 5;
  localparam int REG_DW = 32;

  typedef logic [REG_AW-1:0] reg_addr_t;

  localparam reg_addr_t   REG_ZERO = 5'd0;
  localparam logic [31:0] GP_INIT  = 32'h1000_8000;
endpackage

// File: rtl/regs_wb_sched_rr_arbiter.sv
// Round-robin arbiter with a last-grant pointer.
// Ports:
//   clk, rst_n : clock, async active-low reset
//   req        : per-requester request vector
//   advance    : a grant was taken this cycle; move pointer to the granted index
//   grant      : combinational one-hot grant, search starts at last+1 mod N
module rr_arbiter #(
  parameter int N = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] grant
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  logic [IW-1:0] last;
  logic [IW-1:0] gidx;
  logic          found;
  int            idx;

  always_comb begin
    grant = '0;
    gidx  = last;
    found = 1'b0;
    idx   = 0;
    for (int k = 1; k <= N; k++) begin
      idx = int'(last) + k;
      if (idx >= N) idx = idx - N;
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        gidx       = IW'(idx);
      end
    end
  end

  // Reset to N-1 so that index 0 is searched first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       last <= IW'(N-1);
    else if (advance) last <= gidx;
  end
endmodule

// File: rtl/regs_wb_sched.sv
// Write-back scheduler for the register file.
// Shares the single register-file write port among NREQ write-back sources
// with a round-robin arbiter, and keeps a per-register busy scoreboard so
// issue logic can stall on RAW/WAW hazards.
// Ports:
//   clk, rst_n            : clock, async active-low reset
//   iss_valid/iss_rw      : issuing instruction and its destination
//   rs, rt                : issuing instruction's sources
//   hazard                : any of rs/rt/iss_rw busy (combinational)
//   req_valid/rw/din      : per-source write-back requests (flattened)
//   req_ready             : one-hot grant (combinational)
//   we, rw, din           : registered register-file write port
//   busy                  : registered scoreboard vector
module regs_wb_sched
  import regs_pkg::*;
#(
  parameter int NREQ = 3,
  parameter int AW   = REG_AW,
  parameter int DW   = REG_DW
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               iss_valid,
  input  logic [AW-1:0]      iss_rw,
  input  logic [AW-1:0]      rs,
  input  logic [AW-1:0]      rt,
  output logic               hazard,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ*AW-1:0] req_rw,
  input  logic [NREQ*DW-1:0] req_din,
  output logic [NREQ-1:0]    req_ready,
  output logic               we,
  output logic [AW-1:0]      rw,
  output logic [DW-1:0]      din,
  output logic [2**AW-1:0]   busy
);
  logic          xfer;
  logic [AW-1:0] sel_rw;
  logic [DW-1:0] sel_din;
  logic          iss_set;
  logic [2**AW-1:0] busy_nxt;

  rr_arbiter #(.N(NREQ)) u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req_valid),
    .advance (xfer),
    .grant   (req_ready)
  );

  // Grant is only ever given to a valid source, so any grant is a transfer.
  assign xfer = |(req_valid & req_ready);

  // One-hot mux of the granted source's address/data.
  always_comb begin
    sel_rw  = '0;
    sel_din = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (req_ready[i]) begin
        sel_rw  = sel_rw  | req_rw[i*AW +: AW];
        sel_din = sel_din | req_din[i*DW +: DW];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we  <= 1'b0;
      rw  <= '0;
      din <= '0;
    end else if (xfer) begin
      // Writes to the zero register handshake but never reach the file.
      we  <= (sel_rw != '0);
      rw  <= sel_rw;
      din <= sel_din;
    end else begin
      we  <= 1'b0;
    end
  end

  assign hazard  = busy[rs] | busy[rt] | busy[iss_rw];
  assign iss_set = iss_valid & ~hazard & (iss_rw != '0);

  // Clear first so a same-index set takes precedence.
  always_comb begin
    busy_nxt = busy;
    if (we)      busy_nxt[rw]     = 1'b0;
    if (iss_set) busy_nxt[iss_rw] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy <= '0;
    else        busy <= busy_nxt;
  end
endmodule

// File: tb/tb_regs_wb_sched.sv
module tb_regs_wb_sched;
  localparam int NREQ = 3;
  localparam int AW   = 5;
  localparam int DW   = 32;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               iss_valid;
  logic [AW-1:0]      iss_rw, rs, rt;
  logic               hazard;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ*AW-1:0] req_rw;
  logic [NREQ*DW-1:0] req_din;
  logic [NREQ-1:0]    req_ready;
  logic               we;
  logic [AW-1:0]      rw;
  logic [DW-1:0]      din;
  logic [2**AW-1:0]   busy;

  typedef struct { logic [AW-1:0] rw; logic [DW-1:0] din; } wr_t;
  wr_t exp_q[$];

  int ntests = 0;
  int nfail  = 0;

  regs_wb_sched #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n), .iss_valid(iss_valid), .iss_rw(iss_rw),
    .rs(rs), .rt(rt), .hazard(hazard), .req_valid(req_valid),
    .req_rw(req_rw), .req_din(req_din), .req_ready(req_ready),
    .we(we), .rw(rw), .din(din), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Inputs change just after the falling edge, well away from posedge.
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic set_src(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_rw[i*AW +: AW]  = a;
    req_din[i*DW +: DW] = d;
  endtask

  task automatic expect_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_t w;
    w.rw  = a;
    w.din = d;
    exp_q.push_back(w);
  endtask

  // Monitor: every committed write must match the next expected one.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && we === 1'b1) begin
      if (exp_q.size() == 0) begin
        ntests++;
        nfail++;
        $display("FAIL wr_unexpected: got rw=%0d din=%0h expected no write", rw, din);
      end else begin
        wr_t w;
        w = exp_q.pop_front();
        chk("wr_rw",  64'(rw),  64'(w.rw));
        chk("wr_din", 64'(din), 64'(w.din));
      end
    end
  end

  initial begin
    rst_n = 1'b0; iss_valid = 1'b0; iss_rw = '0; rs = '0; rt = '0;
    req_valid = '0; req_rw = '0; req_din = '0;
    #12;
    chk("rst_we",   64'(we),   64'd0);
    chk("rst_rw",   64'(rw),   64'd0);
    chk("rst_din",  64'(din),  64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    rst_n = 1'b1;

    // Mid-run reset with busy[5] set and a write in flight.
    step(); iss_valid = 1'b1; iss_rw = 5'd5;
    #1 chk("iss5_hazard", 64'(hazard), 64'd0);
    step(); iss_valid = 1'b0; iss_rw = '0;
    chk("busy5_set", 64'(busy[5]), 64'd1);
    req_valid = 3'b001; set_src(0, 5'd3, 32'h111);
    #1 chk("pend_ready", 64'(req_ready), 64'b001);
    @(posedge clk); #1;
    req_valid = '0;
    rst_n = 1'b0;
    #1;
    chk("midrst_we",   64'(we),   64'd0);
    chk("midrst_rw",   64'(rw),   64'd0);
    chk("midrst_din",  64'(din),  64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    step(); rst_n = 1'b1;

    // Round-robin, all three sources valid continuously.
    set_src(0, 5'd1, 32'hA000_0001);
    set_src(1, 5'd2, 32'hB000_0002);
    set_src(2, 5'd3, 32'hC000_0003);
    req_valid = 3'b111;
    for (int n = 0; n < 6; n++) begin
      logic [2:0] g;
      int s;
      s = n % 3;
      g = 3'b001 << s;
      #1 chk("rr_ready", 64'(req_ready), 64'(g));
      expect_wr(5'(s + 1), (s == 0) ? 32'hA000_0001 : (s == 1) ? 32'hB000_0002 : 32'hC000_0003);
      step();
    end
    req_valid = '0;

    // RAW through the scoreboard.
    iss_valid = 1'b1; iss_rw = 5'd7;
    #1 chk("iss7_hazard", 64'(hazard), 64'd0);
    step(); iss_valid = 1'b0; iss_rw = '0;
    chk("busy7_set", 64'(busy[7]), 64'd1);
    rs = 5'd7;
    #1 chk("raw_hazard", 64'(hazard), 64'd1);
    req_valid = 3'b010; set_src(1, 5'd7, 32'hDEAD_BEEF);
    #1 chk("raw_ready", 64'(req_ready), 64'b010);
    expect_wr(5'd7, 32'hDEAD_BEEF);
    step(); req_valid = '0;
    chk("raw_we_cyc", 64'(we), 64'd1);
    chk("raw_hazard_hold", 64'(hazard), 64'd1);
    step();
    chk("raw_hazard_clr", 64'(hazard), 64'd0);
    chk("raw_busy_clr", 64'(busy[7]), 64'd0);
    rs = '0;

    // Zero register: no scoreboard set, no write enable.
    iss_valid = 1'b1; iss_rw = 5'd0;
    #1 chk("zero_hazard", 64'(hazard), 64'd0);
    step(); iss_valid = 1'b0;
    chk("zero_busy", 64'(busy), 64'd0);
    req_valid = 3'b001; set_src(0, 5'd0, 32'h5555_AAAA);
    #1 chk("zero_ready", 64'(req_ready), 64'b001);
    step(); req_valid = '0;
    chk("zero_we", 64'(we), 64'd0);

    // WAW / protocol violation on a busy destination.
    iss_valid = 1'b1; iss_rw = 5'd9;
    step();
    chk("busy9_set", 64'(busy), 64'h200);
    #1 chk("waw_hazard", 64'(hazard), 64'd1);
    step(); iss_valid = 1'b0; iss_rw = '0;
    chk("waw_busy", 64'(busy), 64'h200);

    // Backpressure: park the pointer on source 2, then contend 0 vs 1.
    req_valid = 3'b100; set_src(2, 5'd10, 32'h0000_00CC);
    #1 chk("bp_pre_ready", 64'(req_ready), 64'b100);
    expect_wr(5'd10, 32'h0000_00CC);
    step();
    req_valid = 3'b011;
    set_src(0, 5'd4, 32'h0000_000A);
    set_src(1, 5'd9, 32'h0000_000B);
    #1 chk("bp_ready0", 64'(req_ready), 64'b001);
    expect_wr(5'd4, 32'h0000_000A);
    step();
    set_src(0, 5'd6, 32'h0000_000D);
    #1 chk("bp_ready1", 64'(req_ready), 64'b010);
    expect_wr(5'd9, 32'h0000_000B);
    step();
    req_valid = 3'b001;
    #1 chk("bp_ready0b", 64'(req_ready), 64'b001);
    expect_wr(5'd6, 32'h0000_000D);
    step(); req_valid = '0;
    step();
    chk("bp_busy_clr", 64'(busy), 64'd0);
    chk("q_drained", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
